// File: rtl/dram_arbiter.sv
// Two-requester arbiter for the shared data memory: one access at a time, strobes held
// WAIT_CYCLES cycles, one-cycle ack. Define DRAM_ARB_RR_EN for round-robin tie-breaking.
module dram_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          dram_read,
    output logic          dram_write,
    output logic [AW-1:0] dram_addr,
    output logic [DW-1:0] dram_data_out,
    input  logic [DW-1:0] dram_data_in
);
    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CW       = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          we_q;
    logic          grant;
    logic          win;

    // win: 0 selects m0, 1 selects m1
`ifdef DRAM_ARB_RR_EN
    logic last_owner;

    always_comb begin
        grant = m0_req | m1_req;
        if (m0_req && m1_req) win = ~last_owner;
        else                  win = ~m0_req;
    end

    // Only a completed access moves the round-robin pointer
    always_ff @(posedge clk) begin
        if (reset)              last_owner <= 1'b1;
        else if (state == ACK)  last_owner <= owner;
    end
`else
    always_comb begin
        grant = m0_req | m1_req;
        win   = ~m0_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dram_read  = 1'b0;
        dram_write = 1'b0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_nxt = ACCESS;
            end
            ACCESS: begin
                dram_read  = ~we_q;
                dram_write = we_q;
                if (cnt == '0) state_nxt = ACK;
            end
            ACK: begin
                m0_ack    = ~owner;
                m1_ack    = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are latched at grant so later input changes cannot disturb the access
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            owner         <= 1'b0;
            we_q          <= 1'b0;
            dram_addr     <= '0;
            dram_data_out <= '0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner         <= win;
                        we_q          <= win ? m1_we    : m0_we;
                        dram_addr     <= win ? m1_addr  : m0_addr;
                        dram_data_out <= win ? m1_wdata : m0_wdata;
                        cnt           <= CW'(WAIT_EFF - 1);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            if (owner) m1_rdata <= dram_data_in;
                            else       m0_rdata <= dram_data_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
